// File: rtl/adapter_8_32_r.sv
// Byte-address AXI4-Lite read to 32-bit word read adapter.
// A one-word cache lets lanes 1..3 of the last fetched word skip the master bus.
module adapter_8_32_r (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int unsigned AW = 32;
  localparam int unsigned TW = 30;

  typedef enum logic [2:0] {IDLE, ACK, M_AR, M_R, RESP} state_t;

  state_t          state;
  logic [AW-1:0]   addr_buf;
  logic [AW-1:0]   cache_word;
  logic [TW-1:0]   cache_tag;
  logic            cache_vld;
  logic [1:0]      resp_buf;
  logic            hit_c;
  logic            unused_ok;

  // Lane 0 always misses so that every fresh word access refetches.
  assign hit_c = cache_vld && (addr_buf[1:0] != 2'b00) && (addr_buf[AW-1:2] == cache_tag);

  assign s_axi_rdata  = cache_word;
  assign s_axi_rresp  = resp_buf;
  assign m_axi_arprot = 3'b000;
  assign unused_ok    = ^s_axi_arprot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_buf      <= '0;
      cache_word    <= '0;
      cache_tag     <= '0;
      cache_vld     <= 1'b0;
      resp_buf      <= 2'b00;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi_arvalid) begin
            addr_buf      <= s_axi_araddr;
            s_axi_arready <= 1'b1;
            state         <= ACK;
          end
        end
        ACK: begin
          s_axi_arready <= 1'b0;
          if (hit_c) begin
            resp_buf     <= 2'b00;
            s_axi_rvalid <= 1'b1;
            state        <= RESP;
          end else begin
            m_axi_araddr  <= {addr_buf[AW-1:2], 2'b00};
            m_axi_arvalid <= 1'b1;
            state         <= M_AR;
          end
        end
        M_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= M_R;
          end
        end
        M_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            cache_word   <= m_axi_rdata;
            cache_tag    <= addr_buf[AW-1:2];
            resp_buf     <= m_axi_rresp;
            cache_vld    <= (m_axi_rresp == 2'b00);
            s_axi_rvalid <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Invalidate overrides a coincident fill; the fetched data is still returned.
      if (inv) cache_vld <= 1'b0;
    end
  end

endmodule
